// File: rtl/zuc_pkg.sv
// Shared definitions for the 128-EEA3 controller: FSM state encoding,
// IV byte layout and the helper functions used to build the core IV and
// the tail-word mask.
package zuc_pkg;

    // Controller state encoding
    localparam logic [2:0] ST_FLUSH = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_INIT  = 3'd2;
    localparam logic [2:0] ST_DISC  = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    // Bit positions inside IV byte 4 = {bearer, dir, 2'b00}
    localparam int IV_BEARER_SHIFT = 3;
    localparam int IV_DIR_SHIFT    = 2;

    // Builds the 128-bit IV with IV byte k on bits [8k+7:8k].
    // Bytes 0..3 are COUNT (MSB first), byte 4 carries bearer/dir,
    // bytes 5..7 are zero and bytes 8..15 repeat bytes 0..7.
    function automatic logic [127:0] build_iv(input logic [31:0] count,
                                              input logic [4:0]  bearer,
                                              input logic        dir);
        logic [7:0]  b4;
        logic [63:0] half;
        b4   = (8'(bearer) << IV_BEARER_SHIFT) | (8'(dir) << IV_DIR_SHIFT);
        half = {24'h0, b4, count[7:0], count[15:8], count[23:16], count[31:24]};
        return {half, half};
    endfunction

    // Keeps the first rem bits (MSB first) of the final word; all other
    // words pass unmasked, as does a final word that is completely filled.
    function automatic logic [31:0] tail_mask(input logic       last,
                                              input logic [4:0] rem);
        if (last && (rem != 5'd0)) begin
            return ~(32'hFFFF_FFFF >> rem);
        end
        return 32'hFFFF_FFFF;
    endfunction

endpackage

// File: rtl/zuc_eea3_iv.sv
// Combinational mapping of a latched EEA3 job descriptor onto the zuc core
// IV and key buses (byte k of each on bits [8k+7:8k]).
module zuc_eea3_iv
    import zuc_pkg::*;
(
    input  logic [31:0]  count,
    input  logic [4:0]   bearer,
    input  logic         dir,
    input  logic [127:0] ck,
    output logic [127:0] iv,
    output logic [127:0] key
);

    // CK arrives with byte 0 in the top bits; the core wants byte 0 at the bottom
    always_comb begin
        iv  = build_iv(count, bearer, dir);
        key = '0;
        for (int k = 0; k < 16; k++) begin
            key[8*k +: 8] = ck[127-8*k -: 8];
        end
    end

endmodule

// File: rtl/zuc_eea3_ctrl.sv
// 128-EEA3 job sequencer in front of a shared zuc keystream core.
// Flushes stale core output after reset, initialises the core for each job,
// drops the first keystream word (DISCARD_FIRST), then joins keystream and
// plaintext word by word, masking the tail bits of the final word.
// Optional build macro ZUC_EEA3_CTRL_PERF_EN adds perf_jobs/perf_stall.
module zuc_eea3_ctrl
    import zuc_pkg::*;
#(
    parameter int LEN_W         = 16,
    parameter int DISCARD_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [31:0]      job_count,
    input  logic [4:0]       job_bearer,
    input  logic             job_dir,
    input  logic [127:0]     job_ck,
    input  logic [LEN_W-1:0] job_len,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [31:0]      m_data,
    output logic             m_last,
    output logic             done,
    output logic             z_valid,
    input  logic             z_ready,
    output logic             z_init,
    output logic [127:0]     z_iv,
    output logic [127:0]     z_key,
    input  logic             z_mvalid,
    output logic             z_mready,
    input  logic [31:0]      z_mdata
`ifdef ZUC_EEA3_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_jobs,
    output logic [31:0]      perf_stall
`endif
);

    // Word counters hold up to ceil((2^LEN_W-1)/32) = 2^(LEN_W-5)
    localparam int WRD_W = LEN_W - 4;

    logic [2:0]       state;
    logic             flush_cnt;
    logic [WRD_W-1:0] req_cnt;
    logic [WRD_W-1:0] out_cnt;
    logic             pend;
    logic             disc_sent;
    logic             done_q;

    // Latched job descriptor (data only, no reset needed)
    logic [31:0]      count_q;
    logic [4:0]       bearer_q;
    logic             dir_q;
    logic [127:0]     ck_q;
    logic [WRD_W-1:0] words_q;
    logic [4:0]       rem_q;

    logic             job_fire;
    logic             z_fire;
    logic             consume;
    logic             out_last;
    logic [LEN_W:0]   len_rnd;
    logic [WRD_W-1:0] words_d;

    // One extra bit so that len near 2^LEN_W-1 does not overflow when rounding up
    assign len_rnd  = {1'b0, job_len} + (LEN_W+1)'(31);
    assign words_d  = WRD_W'(len_rnd >> 5);
    assign job_fire = job_valid && job_ready;
    assign out_last = (out_cnt == (words_q - WRD_W'(1)));
    assign z_fire   = z_valid && z_ready;
    assign done     = done_q;

    zuc_eea3_iv u_iv (
        .count  (count_q),
        .bearer (bearer_q),
        .dir    (dir_q),
        .ck     (ck_q),
        .iv     (z_iv),
        .key    (z_key)
    );

    // State-dependent handshakes and the keystream/plaintext output join
    always_comb begin
        job_ready = 1'b0;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_data    = 32'h0;
        m_last    = 1'b0;
        z_valid   = 1'b0;
        z_init    = 1'b0;
        z_mready  = 1'b0;
        consume   = 1'b0;
        case (state)
            ST_FLUSH: begin
                z_mready = 1'b1;
            end
            ST_IDLE: begin
                // Hold off the next job for the cycle that done is still high
                job_ready = !done_q;
                z_mready  = 1'b1;
            end
            ST_INIT: begin
                z_valid = 1'b1;
                z_init  = 1'b1;
            end
            ST_DISC: begin
                z_valid  = !disc_sent;
                z_mready = disc_sent;
            end
            ST_RUN: begin
                m_valid  = z_mvalid && s_valid;
                consume  = m_valid && m_ready;
                s_ready  = consume;
                z_mready = consume;
                // Single outstanding word; refill in the cycle the current one drains
                z_valid  = (req_cnt < words_q) && (!pend || consume);
                m_last   = out_last;
                m_data   = (s_data ^ z_mdata) & tail_mask(out_last, rem_q);
            end
            default: ;
        endcase
    end

    // Sequencer state, request/output counters and the done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FLUSH;
            flush_cnt <= 1'b0;
            req_cnt   <= '0;
            out_cnt   <= '0;
            pend      <= 1'b0;
            disc_sent <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == ST_FIN);
            case (state)
                ST_FLUSH: begin
                    flush_cnt <= 1'b1;
                    if (flush_cnt) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (job_fire) begin
                        req_cnt   <= '0;
                        out_cnt   <= '0;
                        pend      <= 1'b0;
                        disc_sent <= 1'b0;
                        state     <= (job_len == '0) ? ST_FIN : ST_INIT;
                    end
                end
                ST_INIT: begin
                    if (z_ready) begin
                        state <= (DISCARD_FIRST != 0) ? ST_DISC : ST_RUN;
                    end
                end
                ST_DISC: begin
                    if (z_fire) begin
                        disc_sent <= 1'b1;
                    end
                    if (disc_sent && z_mvalid) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (z_fire) begin
                        req_cnt <= req_cnt + WRD_W'(1);
                    end
                    pend <= z_fire || (pend && !consume);
                    if (consume) begin
                        out_cnt <= out_cnt + WRD_W'(1);
                        if (out_last) begin
                            state <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_FLUSH;
                end
            endcase
        end
    end

    // Capture the descriptor and its word count when a job is accepted
    always_ff @(posedge clk) begin
        if (job_fire) begin
            count_q  <= job_count;
            bearer_q <= job_bearer;
            dir_q    <= job_dir;
            ck_q     <= job_ck;
            words_q  <= words_d;
            rem_q    <= job_len[4:0];
        end
    end

`ifdef ZUC_EEA3_CTRL_PERF_EN
    // Completed-job and output-stall counters, free-running and wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_jobs  <= 32'h0;
            perf_stall <= 32'h0;
        end else begin
            if (done_q) begin
                perf_jobs <= perf_jobs + 32'd1;
            end
            if ((state == ST_RUN) && !m_valid) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_zuc_eea3_ctrl.sv
// Self-checking bench for zuc_eea3_ctrl with a behavioural stand-in for the
// zuc core that serves known keystream streams selected by the job key.
module tb_zuc_eea3_ctrl;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             job_valid, job_ready;
    logic [31:0]      job_count;
    logic [4:0]       job_bearer;
    logic             job_dir;
    logic [127:0]     job_ck;
    logic [LEN_W-1:0] job_len;
    logic             s_valid, s_ready;
    logic [31:0]      s_data;
    logic             m_valid, m_ready, m_last;
    logic [31:0]      m_data;
    logic             done;
    logic             z_valid, z_ready, z_init;
    logic [127:0]     z_iv, z_key;
    logic             z_mvalid, z_mready;
    logic [31:0]      z_mdata;
`ifdef ZUC_EEA3_CTRL_PERF_EN
    logic [31:0]      perf_jobs, perf_stall;
`endif

    always #5 clk = ~clk;

    zuc_eea3_ctrl #(.LEN_W(LEN_W), .DISCARD_FIRST(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_count(job_count), .job_bearer(job_bearer), .job_dir(job_dir),
        .job_ck(job_ck), .job_len(job_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .done(done),
        .z_valid(z_valid), .z_ready(z_ready), .z_init(z_init),
        .z_iv(z_iv), .z_key(z_key),
        .z_mvalid(z_mvalid), .z_mready(z_mready), .z_mdata(z_mdata)
`ifdef ZUC_EEA3_CTRL_PERF_EN
        , .perf_jobs(perf_jobs), .perf_stall(perf_stall)
`endif
    );

    // 128-EEA3 test set 1
    localparam logic [127:0] S1_CK  = 128'h173d14ba5003731d7a60049470f00a29;
    localparam logic [127:0] S1_KEY = 128'h290af0709404607a1d730350ba143d17;
    localparam logic [127:0] S1_IV  = 128'h00000078925403660000007892540366;
    logic [31:0] s1_pt [7] = '{32'h6cf65340, 32'h735552ab, 32'h0c9752fa, 32'h6f9025fe,
                               32'h0bd675d9, 32'h005875b2, 32'h00000000};
    logic [31:0] s1_ct [7] = '{32'ha6c85fc6, 32'h6afb8533, 32'haafc2518, 32'hdfe78494,
                               32'h0ee1e4b0, 32'h30238cc8, 32'h00000000};

    typedef struct packed { logic [31:0] data; logic last; } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          bp = 1'b0;
    exp_t        exp_q [$];
    logic [31:0] pt_q [$];
    int          fire_log [$];
    int          done_log [$];
    int          done_cnt = 0;
    int          m_fires = 0;
    int          next_id = -1;
    bit          job_fired = 1'b0;
    bit          s_hold = 1'b0;
    bit          saw_zv = 1'b0;
    bit          saw_mv = 1'b0;
    bit          m_hold = 1'b0;
    logic [31:0] m_hold_data = 32'h0;

    // core model state
    int          busy = 0;
    int          ks_sel = 0;
    int          ks_idx = 0;
    int          req_pend = 0;
    int          wdly = 0;
    logic [31:0] wq [$];
    bit          zm_v = 1'b0;
    logic [31:0] zm_d = 32'h0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Keystream the stand-in core emits after init; word 0 is the one the
    // controller must discard. Set-1 last word carries ones in the bits the
    // tail mask must clear.
    function automatic logic [31:0] ks_word(input int sel, input int idx);
        if (idx == 0) return (sel == 0) ? 32'h5a5a5a5a : 32'ha5a5a5a5;
        if (sel == 0) begin
            if (idx == 1) return 32'h27bede74;
            if (idx == 2) return 32'h018082da;
            return 32'hbad00000 | 32'(idx);
        end
        if (idx <= 6) return s1_pt[idx-1] ^ s1_ct[idx-1];
        if (idx == 7) return (s1_pt[6] ^ s1_ct[6]) | 32'h7fffffff;
        return 32'hbad10000 | 32'(idx);
    endfunction

    task automatic load(input int id);
        case (id)
            0: begin job_count = 32'h0; job_bearer = 5'h0; job_dir = 1'b0;
                     job_ck = 128'h0; job_len = 16'd64; end
            1: begin job_count = 32'h66035492; job_bearer = 5'h0f; job_dir = 1'b0;
                     job_ck = S1_CK; job_len = 16'd193; end
            default: begin job_count = 32'h12345678; job_bearer = 5'h03; job_dir = 1'b1;
                     job_ck = 128'h1; job_len = 16'd0; end
        endcase
    endtask

    // Scoreboard push: plaintext to send and ciphertext the DUT must produce
    task automatic push_vectors(input int id, input bit extra);
        if (id == 0) begin
            pt_q.push_back(32'h0); pt_q.push_back(32'h0);
            exp_q.push_back('{data: 32'h27bede74, last: 1'b0});
            exp_q.push_back('{data: 32'h018082da, last: 1'b1});
            if (extra) pt_q.push_back(32'hdeadbeef);
        end else if (id == 1) begin
            for (int i = 0; i < 7; i++) begin
                pt_q.push_back(s1_pt[i]);
                exp_q.push_back('{data: s1_ct[i], last: (i == 6)});
            end
        end
    endtask

    // Observe the settled pre-edge values and account for every handshake
    task automatic monitor();
        bit mf;
        exp_t e;
        cyc++;
        mf = m_valid && m_ready;
        chk("s_join", 128'(s_ready), 128'(mf));
        if (z_valid) saw_zv = 1'b1;
        if (m_valid) saw_mv = 1'b1;
        if (m_hold && rst_n) chk("m_hold", {95'h0, m_valid, m_data}, {95'h0, 1'b1, m_hold_data});
        m_hold = m_valid && !m_ready && rst_n;
        m_hold_data = m_data;
        if (mf) begin
            m_fires++;
            chk("m_expected", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("m_data", 128'(m_data), 128'(e.data));
                chk("m_last", 128'(m_last), 128'(e.last));
            end
        end
        s_hold = s_valid && !s_ready;
        if (s_valid && s_ready && pt_q.size() > 0) void'(pt_q.pop_front());
        if (done) begin done_cnt++; done_log.push_back(cyc); end
        if (job_valid && job_ready) begin job_fired = 1'b1; fire_log.push_back(cyc); end
        if (z_mvalid && z_mready) begin zm_v = 1'b0; if (req_pend > 0) req_pend--; end
        if (z_valid && z_ready) begin
            if (z_init) begin
                if (z_key === 128'h0) begin
                    ks_sel = 0;
                    chk("iv_zero", z_iv, 128'h0);
                end else begin
                    ks_sel = 1;
                    chk("key_set1", z_key, S1_KEY);
                    chk("iv_set1", z_iv, S1_IV);
                end
                ks_idx = 0;
                busy = 32;
            end else begin
                chk("one_outstanding", 128'(req_pend), 128'(0));
                req_pend++;
                wq.push_back(ks_word(ks_sel, ks_idx));
                ks_idx++;
            end
        end
    endtask

    // Drive the next cycle's inputs just after the active edge
    task automatic drive();
        if (busy > 0) busy--;
        z_ready = (busy == 0) && (!bp || $urandom_range(0, 1) == 1);
        if (!zm_v && wq.size() > 0) begin
            if (wdly == 0) begin
                zm_v = 1'b1;
                zm_d = wq.pop_front();
                wdly = bp ? $urandom_range(0, 3) : 0;
            end else begin
                wdly--;
            end
        end
        z_mvalid = zm_v;
        z_mdata  = zm_d;
        if (!s_hold) s_valid = (pt_q.size() > 0) && (!bp || $urandom_range(0, 1) == 1);
        s_data  = (pt_q.size() > 0) ? pt_q[0] : 32'h0;
        m_ready = !bp || ($urandom_range(0, 2) != 0);
        if (job_fired) begin
            job_fired = 1'b0;
            if (next_id >= 0) begin load(next_id); next_id = -1; end
            else job_valid = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic run(input int id, input bit use_bp, input bit extra, input string tag);
        int d0;
        bp = use_bp;
        saw_zv = 1'b0;
        saw_mv = 1'b0;
        push_vectors(id, extra);
        load(id);
        job_valid = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 4000 && done_cnt == d0; i++) cycle();
        chk({tag, "_done"}, 128'(done_cnt), 128'(d0 + 1));
        chk({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int fl, dl, d0, mf0;
        rst_n = 1'b0; job_valid = 1'b0; job_count = '0; job_bearer = '0; job_dir = 1'b0;
        job_ck = '0; job_len = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        z_ready = 1'b0; z_mvalid = 1'b0; z_mdata = '0;

        repeat (3) cycle();
        chk("rst_outputs", 128'({job_ready, m_valid, m_last, done, z_valid, z_init, s_ready}), 128'(0));
        chk("rst_flush_mready", 128'(z_mready), 128'(1));
        rst_n = 1'b1;
        cycle();
        chk("flush_busy", 128'(job_ready), 128'(0));
        cycle();
        chk("flush_exit", 128'(job_ready), 128'(1));

        // zero key, len=64, with one surplus plaintext word that must stay put
        run(0, 1'b0, 1'b1, "zero64");
        chk("no_overconsume", 128'(pt_q.size()), 128'(1));
        pt_q.delete();
        chk("idle_ready", 128'(job_ready), 128'(1));

        // test set 1
        run(1, 1'b0, 1'b0, "set1");

        // zero-length job
        fl = fire_log.size();
        dl = done_log.size();
        run(2, 1'b0, 1'b0, "len0");
        chk("len0_latency", 128'(done_log[dl] - fire_log[fl]), 128'(2));
        chk("len0_no_core", 128'({saw_zv, saw_mv}), 128'(0));
        chk("len0_ready", 128'(job_ready), 128'(1));

        // set 1 under random backpressure on every interface
        run(1, 1'b1, 1'b0, "set1_bp");
        bp = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // reset during word 3 of set 1, then rerun
        push_vectors(1, 1'b0);
        load(1);
        job_valid = 1'b1;
        d0 = done_cnt;
        mf0 = m_fires;
        for (int i = 0; i < 4000 && (m_fires - mf0) < 3; i++) cycle();
        chk("abort_reach", 128'(m_fires - mf0), 128'(3));
        rst_n = 1'b0;
        job_valid = 1'b0;
        s_valid = 1'b0;
        pt_q.delete();
        exp_q.delete();
        cycle();
        cycle();
        chk("abort_outputs", 128'({m_valid, m_last, done, job_ready}), 128'(0));
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("abort_no_done", 128'(done_cnt), 128'(d0));
        chk("stale_drained", 128'(req_pend + wq.size()), 128'(0));
        run(1, 1'b0, 1'b0, "rerun");

        // back-to-back: set 1 then zero-key len=64, descriptor held valid
        bp = 1'b0;
        push_vectors(1, 1'b0);
        push_vectors(0, 1'b0);
        load(1);
        next_id = 0;
        job_valid = 1'b1;
        fl = fire_log.size();
        dl = done_log.size();
        d0 = done_cnt;
        for (int i = 0; i < 4000 && done_cnt < d0 + 2; i++) cycle();
        chk("b2b_done", 128'(done_cnt), 128'(d0 + 2));
        chk("b2b_drained", 128'(exp_q.size()), 128'(0));
        chk("b2b_fires", 128'(fire_log.size() - fl), 128'(2));
        if (fire_log.size() >= fl + 2 && done_log.size() >= dl + 1)
            chk("b2b_gap", 128'(fire_log[fl+1] > done_log[dl]), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
